// File: rtl/mul_pack.sv
// mul_pack: final stage of the FP32 multiplier pipeline.
// Normalizes the 48-bit mantissa product, rounds to nearest-even and packs
// an IEEE 754 single-precision result. Two register stages with valid/ready
// flow control so the block can stall behind the writeback arbiter.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   in_valid / in_ready            input handshake (in_ready is combinational)
//   in_sign, in_exp_sum, in_prod   sign, biased exponent sum, mantissa product
//   in_nan, in_inf, in_zero        operand class flags
//   out_valid / out_ready          output handshake
//   out_result                     packed IEEE 754 result
//   out_flags                      {invalid, overflow, underflow, inexact}
module mul_pack #(
  parameter int unsigned BIAS    = 127,
  parameter int unsigned EXP_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [8:0]  in_exp_sum,
  input  logic [47:0] in_prod,
  input  logic        in_nan,
  input  logic        in_inf,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);

  localparam int unsigned EW = 10;
  localparam int unsigned MW = 24;
  localparam int unsigned RW = MW + 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic signed [EW-1:0] EMAX = EW'(EXP_MAX);

  logic                 s2_adv;
  logic                 s1_adv;
  logic                 s1_valid;
  logic                 s1_sign;
  logic                 s1_g;
  logic                 s1_s;
  logic                 s1_nan;
  logic                 s1_inf;
  logic                 s1_zero;
  logic signed [EW-1:0] s1_e;
  logic [MW-1:0]        s1_mant;

  // Pipeline advance: a stage moves when it is empty or its successor moves.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Normalize: pick the 24-bit mantissa window by the product's leading bit.
  logic [EW-1:0]        e_base;
  logic signed [EW-1:0] n_e;
  logic [MW-1:0]        n_mant;
  logic                 n_g;
  logic                 n_s;

  always_comb begin
    e_base = EW'(in_exp_sum) - EW'(BIAS);
    n_e    = $signed(e_base);
    n_mant = in_prod[46:23];
    n_g    = in_prod[22];
    n_s    = |in_prod[21:0];
    if (in_prod[47]) begin
      n_e    = $signed(e_base + EW'(1));
      n_mant = in_prod[47:24];
      n_g    = in_prod[23];
      n_s    = |in_prod[22:0];
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_g     <= 1'b0;
      s1_s     <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_e     <= '0;
      s1_mant  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_g    <= n_g;
        s1_s    <= n_s;
        s1_nan  <= in_nan;
        s1_inf  <= in_inf;
        s1_zero <= in_zero;
        s1_e    <= n_e;
        s1_mant <= n_mant;
      end
    end
  end

  // Round to nearest-even, then select the result by class priority.
  logic                 up;
  logic [RW-1:0]        m25;
  logic [22:0]          r_frac;
  logic signed [EW-1:0] r_e;
  logic                 inexact;
  logic                 e_low;
  logic [31:0]          res_c;
  logic [3:0]           flags_c;

  always_comb begin
    up      = s1_g & (s1_s | s1_mant[0]);
    m25     = {1'b0, s1_mant} + RW'(up);
    inexact = s1_g | s1_s;
    r_frac  = m25[22:0];
    r_e     = s1_e;
    // Rounding carried out of the mantissa: renormalize by one.
    if (m25[MW]) begin
      r_frac = m25[23:1];
      r_e    = s1_e + $signed(EW'(1));
    end
    e_low   = r_e[EW-1] || (r_e == '0);
    res_c   = {s1_sign, r_e[7:0], r_frac};
    flags_c = {3'b000, inexact};
    if (s1_inf && s1_zero) begin
      res_c   = QNAN;
      flags_c = 4'b1000;
    end else if (s1_nan) begin
      res_c   = QNAN;
      flags_c = 4'b0000;
    end else if (s1_inf) begin
      res_c   = {s1_sign, 8'hFF, 23'd0};
      flags_c = 4'b0000;
    end else if (s1_zero) begin
      res_c   = {s1_sign, 31'd0};
      flags_c = 4'b0000;
    end else if (r_e >= EMAX) begin
      res_c   = {s1_sign, 8'hFF, 23'd0};
      flags_c = 4'b0101;
    end else if (e_low) begin
      res_c   = {s1_sign, 31'd0};
      flags_c = 4'b0011;
    end
  end

  // Stage 2 register: holds steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res_c;
        out_flags  <= flags_c;
      end
    end
  end

endmodule

// File: doc/mul_pack.md
Name: mul_pack

Overview:
Final stage of the FP32 multiplier pipeline, the inverse of the front-end unpack stage. It takes the sign, biased exponent sum, 48-bit mantissa product and operand-class flags, then normalizes, rounds and repacks them into an IEEE 754 single-precision word. It has two internal register stages with valid/ready flow control, so it can stall behind the FPU writeback arbiter.

Parameters:
BIAS, 127, exponent bias subtracted from the biased exponent sum
EXP_MAX, 255, all-ones exponent; any final exponent at or above this overflows

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  input beat present
in_ready  output  1  block can accept a beat this cycle
in_sign  input  1  result sign (sa XOR sb)
in_exp_sum  input  9  ea + eb, both biased, range 0..510
in_prod  input  48  {1,ma} * {1,mb}
in_nan  input  1  either operand is NaN
in_inf  input  1  either operand is infinite
in_zero  input  1  either operand is zero or denormal
out_valid  output  1  result beat present
out_ready  input  1  consumer takes the beat this cycle
out_result  output  32  packed IEEE 754 result
out_flags  output  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset values:
  - s1_valid = 0, out_valid = 0.
  - out_result = 0, out_flags = 0, all stage-1 registers = 0.
  - in_ready = 1 immediately after reset.
- Reset mid-operation discards all in-flight beats. No output is produced for them.
- Flow control:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational).
  - A beat is accepted when in_valid & in_ready.
- Latency and throughput: latency is 2 cycles from acceptance to out_valid when out_ready stays high. Throughput is 1 beat per cycle.
- Output stability: while out_valid & !out_ready, out_result and out_flags hold steady.
- Stage 1 (normalize):
  - If prod[47]=1: mant = prod[47:24], g = prod[23], s = |prod[22:0], e = exp_sum - BIAS + 1.
  - Else: mant = prod[46:23], g = prod[22], s = |prod[21:0], e = exp_sum - BIAS.
  - e is 10-bit signed.
  - Sign and class flags are registered alongside.
- Stage 2 (round-to-nearest-even):
  - up = g & (s | mant[0]).
  - m25 = mant + up.
  - If m25[24]=1: mant becomes m25[24:1] and e increments by 1.
  - inexact = g | s.
- Stage 2 result selection, highest priority first:
  1. in_inf & in_zero: result 0x7FC00000, invalid = 1.
  2. in_nan: result 0x7FC00000. No flags.
  3. in_inf: result {sign, 0xFF, 0}. No flags.
  4. in_zero: result {sign, 31'b0}. No flags.
  5. e >= EXP_MAX: result {sign, 0xFF, 0}, overflow = 1, inexact = 1.
  6. e <= 0: result {sign, 31'b0} (flush to zero), underflow = 1, inexact = 1.
  7. Otherwise: result {sign, e[7:0], mant[22:0]}, inexact as computed.
- Flags are valid only with out_valid. They are not sticky; accumulation happens in fcsr, outside this block.

Test Plan:
- 1.5*2.0: sign 0, exp_sum 255, prod 0x600000000000, out_ready high.
  -> out_valid 2 cycles after acceptance, result 0x40400000, flags 0000.
- RNE tie and round-up: exp_sum 254 with prod 0x400000400000, then with prod 0x400000C00000.
  -> results 0x3F800000 and 0x3F800002, both with inexact = 1.
- Mantissa carry on round: exp_sum 254, prod 0x7FFFFFC00000.
  -> result 0x40000000, inexact = 1.
- Overflow and underflow: exp_sum 400, prod 0x400000000000, sign 1.
  -> result 0xFF800000, flags 0101.
  Then exp_sum 100, same prod, sign 0.
  -> result 0x00000000, flags 0011.
- Specials: in_inf = in_zero = 1 -> result 0x7FC00000, flags 1000. in_inf only with sign 1 -> result 0xFF800000.
- Backpressure and reset: out_ready low, 3 back-to-back beats offered.
  -> 2 beats accepted, in_ready low on the 3rd, out_result held.
  Raise out_ready -> beats drain in order.
  Assert rst mid-stall -> out_valid = 0 at once, no stale beat after release.
